// File: rtl/display_source.sv
// rtl/display_source.sv - register-file shadow display with debounced register selector
module display_source #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACT_CYCLES      = 12500000
) (
    input  logic        clock_50,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        freeze,
    input  logic        btn_next,
    output logic [15:0] R0,
    output logic [15:0] R1,
    output logic [15:0] R2,
    output logic [15:0] R3,
    output logic [15:0] R4,
    output logic [15:0] R5,
    output logic [15:0] R6,
    output logic [15:0] R7,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        HEX0_DP,
    output logic        HEX1_DP,
    output logic        HEX2_DP,
    output logic        HEX3_DP,
    output logic        HEX4_DP,
    output logic        HEX5_DP,
    output logic        HEX6_DP,
    output logic        HEX7_DP,
    output logic [2:0]  sel
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0]    ACT_LOAD = 24'(ACT_CYCLES);

    logic [15:0]   shadow [8];
    logic [23:0]   act_cnt [8];
    logic          sync_meta;
    logic          sync_btn;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] db_cnt;
    logic          step;
    logic [2:0]    sel_nxt;
    logic          wr_ok;
    logic [15:0]   cur_val;
    logic [15:0]   nxt_val;

    assign wr_ok   = wr_en && !freeze;
    assign sel_nxt = sel + 3'd1;
    assign cur_val = shadow[sel];
    assign nxt_val = shadow[sel_nxt];

    assign R0 = shadow[0];
    assign R1 = shadow[1];
    assign R2 = shadow[2];
    assign R3 = shadow[3];
    assign R4 = shadow[4];
    assign R5 = shadow[5];
    assign R6 = shadow[6];
    assign R7 = shadow[7];

    assign HEX1_DP = 1'b0;
    assign HEX2_DP = 1'b0;
    assign HEX5_DP = 1'b0;
    assign HEX6_DP = 1'b0;
    assign HEX7_DP = 1'b0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    // Shadow register writes (dropped while frozen) and per-register activity timers
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i]  <= 16'h0000;
                act_cnt[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_ok && wr_addr == 3'(i)) begin
                    shadow[i]  <= wr_data;
                    act_cnt[i] <= ACT_LOAD;
                end else if (act_cnt[i] != 24'd0) begin
                    act_cnt[i] <= act_cnt[i] - 24'd1;
                end
            end
        end
    end

    // Two-flop synchronizer for the raw pushbutton; idles high (released)
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= 1'b1;
            sync_btn  <= 1'b1;
        end else begin
            sync_meta <= btn_next;
            sync_btn  <= sync_meta;
        end
    end

    // Debounce state register
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Debounce counter: restarts on every state change, counts only while waiting
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn)                                              db_cnt <= '0;
        else if (state_nxt != state)                              db_cnt <= '0;
        else if (state == PRESS_WAIT || state == RELEASE_WAIT)    db_cnt <= db_cnt + CW'(1);
    end

    // Debounce next-state; step fires only on the accepted press
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            IDLE:         if (!sync_btn) state_nxt = PRESS_WAIT;
            PRESS_WAIT: begin
                if (sync_btn) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    step      = 1'b1;
                end
            end
            PRESSED:      if (sync_btn) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (!sync_btn)               state_nxt = PRESSED;
                else if (db_cnt == DB_LAST)  state_nxt = IDLE;
            end
            default:      state_nxt = IDLE;
        endcase
    end

    // Selected register index advances once per accepted press, wrapping 7 to 0
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn)   sel <= 3'd0;
        else if (step) sel <= sel_nxt;
    end

    // Registered seven-segment and decimal-point outputs
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            HEX0 <= 7'h3F; HEX1 <= 7'h3F; HEX2 <= 7'h3F; HEX3 <= 7'h3F;
            HEX4 <= 7'h3F; HEX5 <= 7'h3F; HEX6 <= 7'h3F; HEX7 <= 7'h3F;
            HEX0_DP <= 1'b0;
            HEX3_DP <= 1'b0;
            HEX4_DP <= 1'b0;
        end else begin
            HEX0 <= seg7(cur_val[3:0]);
            HEX1 <= seg7(cur_val[7:4]);
            HEX2 <= seg7(cur_val[11:8]);
            HEX3 <= seg7(cur_val[15:12]);
            HEX4 <= seg7(nxt_val[3:0]);
            HEX5 <= seg7(nxt_val[7:4]);
            HEX6 <= seg7(nxt_val[11:8]);
            HEX7 <= seg7(nxt_val[15:12]);
            HEX0_DP <= (act_cnt[sel] != 24'd0);
            HEX4_DP <= (act_cnt[sel_nxt] != 24'd0);
            HEX3_DP <= freeze;
        end
    end

endmodule

// File: tb/tb_display_source.sv
// tb/tb_display_source.sv - directed self-checking bench for display_source
module tb_display_source;

    logic        clock_50 = 1'b0;
    logic        resetn = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_data = 16'h0;
    logic        freeze = 1'b0;
    logic        btn_next = 1'b1;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic        HEX0_DP, HEX1_DP, HEX2_DP, HEX3_DP, HEX4_DP, HEX5_DP, HEX6_DP, HEX7_DP;
    logic [2:0]  sel;

    int n_tests = 0;
    int n_fail  = 0;

    display_source #(.DEBOUNCE_CYCLES(4), .ACT_CYCLES(8)) dut (
        .clock_50(clock_50), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .freeze(freeze), .btn_next(btn_next),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
        .HEX0_DP(HEX0_DP), .HEX1_DP(HEX1_DP), .HEX2_DP(HEX2_DP), .HEX3_DP(HEX3_DP),
        .HEX4_DP(HEX4_DP), .HEX5_DP(HEX5_DP), .HEX6_DP(HEX6_DP), .HEX7_DP(HEX7_DP),
        .sel(sel)
    );

    always #5 clock_50 = ~clock_50;

    typedef struct {
        logic        fr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_r;
        logic [6:0]  exp_lo;
        logic [6:0]  exp_hi;
        logic        exp_dp3;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_r(input logic [2:0] a);
        case (a)
            3'd0: rd_r = R0; 3'd1: rd_r = R1; 3'd2: rd_r = R2; 3'd3: rd_r = R3;
            3'd4: rd_r = R4; 3'd5: rd_r = R5; 3'd6: rd_r = R6; default: rd_r = R7;
        endcase
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Clean press: step lands on the 7th edge after btn falls, then a full release
    task automatic press(input logic [2:0] old_sel, input logic [2:0] new_sel);
        btn_next = 1'b0;
        repeat (6) tick();
        chk("sel_before_step", 32'(sel), 32'(old_sel));
        tick();
        chk("sel_after_step", 32'(sel), 32'(new_sel));
        tick();
        btn_next = 1'b1;
        repeat (10) tick();
        chk("sel_after_release", 32'(sel), 32'(new_sel));
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'd0, 16'h1234, 16'h1234, 7'h66, 7'h06, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 16'hFFFF, 16'h1234, 7'h66, 7'h06, 1'b1};
        vecs[2] = '{1'b0, 3'd1, 16'hABCD, 16'hABCD, 7'h5E, 7'h77, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 16'h90E7, 16'h90E7, 7'h07, 7'h6F, 1'b0};
        vecs[4] = '{1'b1, 3'd1, 16'h0000, 16'hABCD, 7'h5E, 7'h77, 1'b1};
        vecs[5] = '{1'b0, 3'd1, 16'h8C2F, 16'h8C2F, 7'h71, 7'h7F, 1'b0};

        // Asynchronous reset values, before any clock edge
        #2 resetn = 1'b0;
        #1;
        chk("rst_R0", 32'(R0), 32'h0);
        chk("rst_R7", 32'(R7), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_HEX0", 32'(HEX0), 32'h3F);
        chk("rst_HEX7", 32'(HEX7), 32'h3F);
        chk("rst_DP0", 32'(HEX0_DP), 32'h0);
        chk("rst_DP3", 32'(HEX3_DP), 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // Table of writes at sel=0 (R0 on HEX3..0, R1 on HEX7..4)
        for (int i = 0; i < 6; i++) begin
            freeze = vecs[i].fr;
            wr(vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_R", i), 32'(rd_r(vecs[i].addr)), 32'(vecs[i].exp_r));
            tick();
            if (vecs[i].addr == 3'd0) begin
                chk($sformatf("vec%0d_lo", i), 32'(HEX0), 32'(vecs[i].exp_lo));
                chk($sformatf("vec%0d_hi", i), 32'(HEX3), 32'(vecs[i].exp_hi));
            end else begin
                chk($sformatf("vec%0d_lo", i), 32'(HEX4), 32'(vecs[i].exp_lo));
                chk($sformatf("vec%0d_hi", i), 32'(HEX7), 32'(vecs[i].exp_hi));
            end
            chk($sformatf("vec%0d_dp3", i), 32'(HEX3_DP), 32'(vecs[i].exp_dp3));
            freeze = 1'b0;
        end

        // Frozen write from a clean state leaves no data and no activity dot
        do_reset();
        freeze = 1'b1;
        wr(3'd0, 16'h1234);
        tick();
        chk("frz_R0", 32'(R0), 32'h0);
        chk("frz_DP3", 32'(HEX3_DP), 32'h1);
        chk("frz_DP0", 32'(HEX0_DP), 32'h0);
        chk("frz_sel", 32'(sel), 32'h0);
        freeze = 1'b0;
        tick();
        chk("frz_DP3_off", 32'(HEX3_DP), 32'h0);

        // Bounce: 2 low, 1 high, 3 low -> no step; then a clean press
        do_reset();
        btn_next = 1'b0; repeat (2) tick();
        btn_next = 1'b1; tick();
        btn_next = 1'b0; repeat (3) tick();
        btn_next = 1'b1; repeat (12) tick();
        chk("bounce_no_step", 32'(sel), 32'h0);
        press(3'd0, 3'd1);

        // BEEF in R2, selected by two presses
        do_reset();
        wr(3'd2, 16'hBEEF);
        chk("beef_R2", 32'(R2), 32'hBEEF);
        press(3'd0, 3'd1);
        press(3'd1, 3'd2);
        chk("beef_HEX3", 32'(HEX3), 32'h7C);
        chk("beef_HEX2", 32'(HEX2), 32'h79);
        chk("beef_HEX1", 32'(HEX1), 32'h79);
        chk("beef_HEX0", 32'(HEX0), 32'h71);

        // Write and step on the same edge: HEX shows new sel and new data one cycle later
        btn_next = 1'b0;
        repeat (6) tick();
        wr(3'd3, 16'h5A3C);
        chk("same_sel", 32'(sel), 32'h3);
        chk("same_R3", 32'(R3), 32'h5A3C);
        chk("same_HEX0_old", 32'(HEX0), 32'h71);
        tick();
        chk("same_HEX0", 32'(HEX0), 32'h39);
        chk("same_HEX3", 32'(HEX3), 32'h6D);
        btn_next = 1'b1;
        repeat (10) tick();

        // Walk to sel=7, neighbour display wraps to R0, then a full lap
        wr(3'd0, 16'h7C05);
        for (int s = 3; s < 7; s++) press(3'(s), 3'(s + 1));
        tick();
        chk("wrap_HEX4", 32'(HEX4), 32'h6D);
        chk("wrap_HEX5", 32'(HEX5), 32'h3F);
        chk("wrap_HEX6", 32'(HEX6), 32'h39);
        chk("wrap_HEX7", 32'(HEX7), 32'h07);
        for (int s = 7; s < 15; s++) press(3'(s), 3'(s + 1));
        chk("lap_end_sel", 32'(sel), 32'h7);

        // Activity dot: 8 cycles, a rewrite at cycle 5 stretches it to cycle 13
        do_reset();
        wr(3'd0, 16'h0001);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("act_k%0d", k), 32'(HEX0_DP), 32'(k <= 8));
        end
        do_reset();
        wr(3'd0, 16'h0002);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0003;
            end
            tick();
            wr_en = 1'b0;
            chk($sformatf("rew_k%0d", k), 32'(HEX0_DP), 32'(k <= 13));
            chk($sformatf("rew_dp4_k%0d", k), 32'(HEX4_DP), 32'h0);
        end

        // Reset in the middle of a press and of an activity interval
        do_reset();
        wr(3'd0, 16'hCAFE);
        wr(3'd1, 16'h0F0F);
        btn_next = 1'b0;
        repeat (4) tick();
        chk("mid_DP0_set", 32'(HEX0_DP), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_R0", 32'(R0), 32'h0);
        chk("mid_R1", 32'(R1), 32'h0);
        chk("mid_HEX0", 32'(HEX0), 32'h3F);
        chk("mid_HEX4", 32'(HEX4), 32'h3F);
        chk("mid_DP0", 32'(HEX0_DP), 32'h0);
        chk("mid_DP4", 32'(HEX4_DP), 32'h0);
        btn_next = 1'b1;
        tick();
        resetn = 1'b1;
        repeat (20) tick();
        chk("mid_sel", 32'(sel), 32'h0);
        chk("mid_DP0_after", 32'(HEX0_DP), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_source.md
DISPLAY_SOURCE -- requirements
Module: display_source

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable cycles (10 ms at 50 MHz) before a button level change is accepted.
REQ-002 SHALL have parameter ACT_CYCLES, default 12500000, meaning cycles a register's activity dot stays lit after a write (24-bit counter).
REQ-003 SHALL have port clock_50  in  1  meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  in  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  in  1  meaning processor register-file write strobe.
REQ-006 SHALL have port wr_addr  in  3  meaning destination register index.
REQ-007 SHALL have port wr_data  in  16  meaning write data.
REQ-008 SHALL have port freeze  in  1  meaning a level that holds the display by dropping writes.
REQ-009 SHALL have port btn_next  in  1  meaning raw asynchronous pushbutton, 0 = pressed.
REQ-010 SHALL have ports R0..R7  out  16 each  meaning the shadow register values, which feed the LED matrix rows.
REQ-011 SHALL have ports HEX0..HEX7  out  7 each  meaning active-high segments {g,f,e,d,c,b,a}, with a in bit 0.
REQ-012 SHALL have ports HEX0_DP..HEX7_DP  out  1 each  meaning active-high decimal points.
REQ-013 SHALL have port sel  out  3  meaning the currently selected register index.

Function
REQ-014 SHALL, on a clock edge with wr_en=1 and freeze=0, write wr_data into shadow[wr_addr], visible on Rn after that edge.
REQ-015 SHALL discard writes while freeze=1 (no queueing), leaving the shadow registers unchanged.
REQ-016 SHALL pass btn_next through a 2-flop synchronizer before any use.
REQ-017 SHALL implement a debounce FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, and one cycle counter cleared on every state entry.
REQ-018 SHALL apply these FSM transitions: IDLE goes to PRESS_WAIT on sync=0; PRESS_WAIT goes to IDLE on sync=1, else to PRESSED when the count reaches DEBOUNCE_CYCLES-1; PRESSED goes to RELEASE_WAIT on sync=1; RELEASE_WAIT goes to PRESSED on sync=0, else to IDLE when the count reaches DEBOUNCE_CYCLES-1.
REQ-019 SHALL emit exactly one internal 1-cycle step pulse on each PRESS_WAIT-to-PRESSED transition, and none on release.
REQ-020 SHALL, on a step pulse, set sel to sel+1 modulo 8, wrapping 7 to 0.
REQ-021 SHALL drive HEX3..HEX0 with shadow[sel] nibbles [15:12]..[3:0], and HEX7..HEX4 with shadow[(sel+1) mod 8] nibbles [15:12]..[3:0].
REQ-022 SHALL register the HEX outputs, giving exactly 1 cycle of latency after the shadow or sel update.
REQ-023 SHALL use these glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex).
REQ-024 SHALL keep one activity counter per register, loaded with ACT_CYCLES on an accepted write, decremented to 0 and saturating there; the register is "active" while its counter is nonzero.
REQ-025 SHALL reload a register's activity counter on a repeat write while it is still nonzero.
REQ-026 SHALL drive HEX0_DP = active(sel), HEX4_DP = active((sel+1) mod 8) and HEX3_DP = freeze, all registered with HEX timing; all other DPs SHALL be 0.
REQ-027 SHALL apply both effects when a write and a step pulse land in the same cycle; the next-cycle HEX SHALL reflect the new sel and the new data.
REQ-028 SHALL never let a freeze transition alter sel or the debounce FSM.

Reset
REQ-029 SHALL, when resetn=0, immediately (asynchronously) clear shadow R0..R7 to 0, sel to 0, the FSM to IDLE, the debounce and activity counters to 0, the synchronizer flops to 1, HEX0..HEX7 to 7'h3F and all DPs to 0.
REQ-030 SHALL abort an in-progress debounce or activity interval on reset mid-operation, with no step pulse after release.
REQ-031 SHALL resume normal operation on the first rising clock_50 edge after resetn deasserts.

Verification (DEBOUNCE_CYCLES=4, ACT_CYCLES=8)
REQ-032 SHALL cover: write addr 2 data 16'hBEEF, then press btn_next long enough to give sel=2 -> R2=BEEF, and the next cycle HEX3..HEX0=7C,79,79,71.
REQ-033 SHALL cover: freeze=1, write addr 0 data 16'h1234 -> R0 stays 0000, HEX3_DP=1, no activity dot.
REQ-034 SHALL cover: btn_next low for 2 cycles, high, then low for 3 cycles -> no step; a clean press of 6 cycles or more -> exactly one step, sel 0->1.
REQ-035 SHALL cover: 8 clean presses starting from sel=7 -> sel wraps to 0 after the first press, then ends at 7; at sel=7, HEX7..HEX4 show R0.
REQ-036 SHALL cover: write R0 with sel=0 -> HEX0_DP=1 for 8 cycles then 0; a rewrite at cycle 5 extends it to cycle 13.
REQ-037 SHALL cover: resetn pulsed low during PRESS_WAIT and with active dots set -> all outputs at reset values, no step after release, sel=0.
